// File: rtl/mac_vector_sequencer.sv
// Control stage around the 4-lane MAC: it walks num_words operand words over memory port B and fires the MAC once per word.
// It accumulates the per-word results into a wide unsigned sum. Define MAC_SEQ_TIMEOUT_EN to add a WAIT_MAC watchdog that drives err.
module mac_vector_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int LEN_WIDTH   = 8,
  parameter int ACC_WIDTH   = 48,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    num_words,
  output logic                    busy,
  output logic                    done,
  output logic [ACC_WIDTH-1:0]    acc_result,
  output logic                    overflow,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   addrb,
  output logic                    enb,
  output logic                    start_mac,
  input  logic [2*DATA_WIDTH-1:0] mac_result,
  input  logic                    mac_done
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_MEM,
    FIRE,
    WAIT_MAC,
    FINISH
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_num;
  logic [LEN_WIDTH-1:0]  r_idx;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_accResult;
  logic [LAT_W-1:0]      r_lat;
  logic [ADDR_WIDTH-1:0] r_addrb;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;
  logic                  r_enb;
  logic                  r_startMac;
`ifdef MAC_SEQ_TIMEOUT_EN
  logic [3:0]            r_wdog;
  logic                  r_err;
`endif

  logic [ACC_WIDTH:0]    w_sum;
  logic [LEN_WIDTH:0]    w_idxNext;

  // The extra top bit of the sum is the carry out that feeds the sticky overflow flag.
  assign w_sum     = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - 2*DATA_WIDTH){1'b0}}, mac_result};
  assign w_idxNext = {1'b0, r_idx} + (LEN_WIDTH + 1)'(1);

  // All outputs are registered and take their value on entry to the state that owns them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_num       <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_accResult <= '0;
      r_lat       <= '0;
      r_addrb     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_enb       <= 1'b0;
      r_startMac  <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
      r_wdog      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_enb      <= 1'b0;
      r_startMac <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base <= base_addr;
            r_num  <= num_words;
            r_idx  <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
            if (num_words == '0) begin
              r_state     <= FINISH;
              r_done      <= 1'b1;
              r_accResult <= '0;
              r_busy      <= 1'b0;
            end else begin
              r_state <= ISSUE;
              r_busy  <= 1'b1;
              r_enb   <= 1'b1;
              r_addrb <= base_addr;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT_MEM;
          r_lat   <= '0;
        end
        WAIT_MEM: begin
          if (r_lat == LAT_LAST) begin
            r_state    <= FIRE;
            r_startMac <= 1'b1;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        FIRE: begin
          r_state <= WAIT_MAC;
`ifdef MAC_SEQ_TIMEOUT_EN
          r_wdog  <= '0;
`endif
        end
        WAIT_MAC: begin
          if (mac_done) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
            if (w_sum[ACC_WIDTH]) begin
              r_ovf <= 1'b1;
            end
            r_idx <= w_idxNext[LEN_WIDTH-1:0];
            if (w_idxNext == {1'b0, r_num}) begin
              r_state     <= FINISH;
              r_done      <= 1'b1;
              r_accResult <= w_sum[ACC_WIDTH-1:0];
              r_busy      <= 1'b0;
            end else begin
              r_state <= ISSUE;
              r_enb   <= 1'b1;
              r_addrb <= r_base + ADDR_WIDTH'(w_idxNext);
            end
`ifdef MAC_SEQ_TIMEOUT_EN
          end else if (r_wdog == 4'd14) begin
            // Fifteenth silent cycle: report only the words that did complete.
            r_err       <= 1'b1;
            r_state     <= FINISH;
            r_done      <= 1'b1;
            r_accResult <= r_acc;
            r_busy      <= 1'b0;
          end else begin
            r_wdog <= r_wdog + 4'd1;
`endif
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign acc_result = r_accResult;
  assign overflow   = r_ovf;
  assign addrb      = r_addrb;
  assign enb        = r_enb;
  assign start_mac  = r_startMac;
`ifdef MAC_SEQ_TIMEOUT_EN
  assign err        = r_err;
`else
  assign err        = 1'b0;
`endif

endmodule
